uart_cmd_parser: RTL and testbench
==================================

// Module: uart_cmd_parser
// PURPOSE
//  Consumer of the UART core's RX FIFO and producer into its TX FIFO. It pops received bytes, parses
//  ASCII command lines, updates an 8-bit LED register and queues an ASCII reply into the TX FIFO.
//  It replaces the button-driven loopback on the Basys 3 UART verification path.
// PARAMETERS
//  LED_RESET       8'h00        value loaded into led on reset
//  TIMEOUT_CYCLES  100_000_000  mid-command idle limit in CLK cycles (CMD_TIMEOUT_EN only); 1 s at 100 MHz
// PORTS
//  CLK        in   1  100 MHz system clock
//  RST_N      in   1  synchronous reset, active-low
//  rx_empty   in   1  RX FIFO empty
//  read_data  in   8  RX FIFO head byte (first-word-fall-through: valid whenever rx_empty=0)
//  read_uart  out  1  RX FIFO pop strobe, 1 cycle
//  tx_full    in   1  TX FIFO full
//  write_uart out  1  TX FIFO push strobe, 1 cycle
//  write_data out  8  byte pushed with write_uart
//  led        out  8  LED register
//  cmd_stb    out  1  1-cycle pulse when a W command commits
//  err_cnt    out  8  count of rejected/aborted commands, saturates at 8'hFF
// BEHAVIOUR
//  Reset (RST_N=0 at a CLK edge) sets led=LED_RESET, read_uart=0, write_uart=0, write_data=8'h00,
//  cmd_stb=0, err_cnt=0 and the state to IDLE. Any partial command or queued reply is discarded.
//  Commands are case-insensitive, and hex digits are 0-9, A-F or a-f:
//   - W h h CR: write led.
//   - R CR: read led.
//  RX pop rule:
//   - In a receive state with rx_empty=0, assert read_uart for 1 cycle and consume read_data in that same cycle.
//   - read_uart is forced low on the next cycle, so at most 1 pop every 2 cycles.
//   - There are no pops in SEND.
//  FSM: IDLE, W_HI, W_LO, W_END, R_END, FLUSH, SEND.
//   - IDLE: 'W'->W_HI, 'R'->R_END, CR/LF ignored, any other byte->FLUSH.
//   - W_HI: hex digit->latch high nibble, go W_LO. W_LO: hex digit->latch low nibble, go W_END.
//     Non-hex in W_HI or W_LO: CR->error reply, any other byte->FLUSH.
//   - W_END: CR->led<=nibbles; cmd_stb=1 in the cycle after the CR pop, same edge as the led update;
//     reply "K\r\n". Any other byte->FLUSH.
//   - R_END: CR->reply of 2 uppercase hex chars of led then "\r\n". Any other byte->FLUSH.
//   - FLUSH: discard bytes until CR, then error reply "?\r\n".
//   - Each error reply increments err_cnt by 1 (saturating).
//   - LF is treated as an ordinary byte in every state except IDLE.
//  SEND:
//   - The reply is held in a 4-byte buffer with a length of 3 or 4.
//   - Each cycle tx_full=0: write_uart=1 with write_data=next byte, then index+1.
//   - tx_full=1: write_uart=0 and the index holds. No byte is dropped or duplicated.
//   - After the last byte the FSM returns to IDLE.
//   - The R reply samples led at the CR pop, so the reply is coherent.
//  Latency: the first reply byte is pushed 2 cycles after the CR pop if tx_full=0.
// CONFIGURATION
//  CMD_TIMEOUT_EN defined:
//   - A counter runs in W_HI, W_LO, W_END, R_END and FLUSH, and clears on every pop.
//   - On reaching TIMEOUT_CYCLES: go to IDLE, err_cnt+1, no reply.
//   - The counter width is $clog2(TIMEOUT_CYCLES+1).
//  CMD_TIMEOUT_EN undefined: no counter logic; partial commands wait indefinitely.
// TESTING
//  1. Bytes "W5A\r" -> led=8'h5A, one cmd_stb pulse, TX bytes 0x4B 0x0D 0x0A.
//  2. Then "r\r" -> TX bytes 0x35 0x41 0x0D 0x0A; led unchanged; err_cnt=0.
//  3. "Wg1\r" and "X\r" -> each reply 0x3F 0x0D 0x0A; led unchanged; err_cnt=2.
//  4. "R\r" with tx_full=1 for 20 cycles mid-reply -> write_uart=0 throughout that window;
//     after release exactly 4 bytes, correct order.
//  5. "W3" then RST_N=0 for 1 cycle, then "R\r" -> led=LED_RESET, reply "00\r\n",
//     no stale byte in the reply, err_cnt=0.
//  6. CMD_TIMEOUT_EN with TIMEOUT_CYCLES=50: "W1", idle 50 cycles -> IDLE, err_cnt=1, no TX;
//     then "W22\r" -> led=8'h22.

Source files
------------

// File: rtl/uart_cmd_parser_if.sv
// FIFO-side handshake bundle between the command parser and the UART RX/TX FIFOs.
// master = parser (pops RX, pushes TX); slave = FIFO side.
interface uart_cmd_parser_if;
  logic       rx_empty;
  logic [7:0] read_data;
  logic       read_uart;
  logic       tx_full;
  logic       write_uart;
  logic [7:0] write_data;

  modport master (
    input  rx_empty, read_data, tx_full,
    output read_uart, write_uart, write_data
  );

  modport slave (
    output rx_empty, read_data, tx_full,
    input  read_uart, write_uart, write_data
  );
endinterface

// File: rtl/uart_cmd_parser.sv
// ASCII command parser: "W hh CR" writes led, "R CR" reads it back; replies are queued into the TX FIFO.
// Reply is pushed 2 cycles after the CR pop; TX stalls on tx_full. CMD_TIMEOUT_EN adds a mid-command timeout.
module uart_cmd_parser #(
  parameter logic [7:0] LED_RESET = 8'h00
`ifdef CMD_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYCLES = 100_000_000
`endif
) (
  input  logic               CLK,
  input  logic               RST_N,
  uart_cmd_parser_if.master  bus,
  output logic [7:0]         led,
  output logic               cmd_stb,
  output logic [7:0]         err_cnt
);

  typedef enum logic [2:0] {IDLE, W_HI, W_LO, W_END, R_END, FLUSH, SEND} state_t;

  localparam logic [7:0]  CH_CR   = 8'h0D;
  localparam logic [7:0]  CH_LF   = 8'h0A;
  localparam logic [7:0]  CH_W    = 8'h57;
  localparam logic [7:0]  CH_R    = 8'h52;
  localparam logic [31:0] OK_RPL  = {8'h00, CH_LF, CH_CR, 8'h4B};
  localparam logic [31:0] ERR_RPL = {8'h00, CH_LF, CH_CR, 8'h3F};

  state_t          state_q;
  logic [7:0]      led_q;
  logic            read_uart_q;
  logic            write_uart_q;
  logic [7:0]      write_data_q;
  logic            cmd_stb_q;
  logic [7:0]      err_cnt_q;
  logic [7:0]      wdat_q;
  logic [3:0][7:0] rbuf_q;
  logic [1:0]      last_q;
  logic [1:0]      idx_q;

  logic [7:0]      rx_up;
  logic            hex_vld;
  logic [3:0]      hex_nib;
  logic [7:0]      err_cnt_d;

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    hex_char = (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  always_comb begin
    rx_up   = bus.read_data;
    hex_vld = 1'b0;
    hex_nib = 4'h0;
    if (bus.read_data >= 8'h61 && bus.read_data <= 8'h7A) rx_up = bus.read_data - 8'h20;
    if (rx_up >= 8'h30 && rx_up <= 8'h39) begin
      hex_vld = 1'b1;
      hex_nib = rx_up[3:0];
    end else if (rx_up >= 8'h41 && rx_up <= 8'h46) begin
      hex_vld = 1'b1;
      hex_nib = rx_up[3:0] + 4'd9;
    end
    err_cnt_d = (err_cnt_q == 8'hFF) ? err_cnt_q : err_cnt_q + 8'd1;
  end

`ifdef CMD_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] to_cnt_q;
  logic          to_run;
  logic          to_hit;
  // Idle time only accrues while a command is partially received; every pop restarts it.
  assign to_run = (state_q inside {W_HI, W_LO, W_END, R_END, FLUSH}) && !read_uart_q;
  assign to_hit = (to_cnt_q == TW'(TIMEOUT_CYCLES));
`endif

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q      <= IDLE;
      led_q        <= LED_RESET;
      read_uart_q  <= 1'b0;
      write_uart_q <= 1'b0;
      write_data_q <= 8'h00;
      cmd_stb_q    <= 1'b0;
      err_cnt_q    <= 8'h00;
      wdat_q       <= 8'h00;
      rbuf_q       <= '0;
      last_q       <= 2'd0;
      idx_q        <= 2'd0;
`ifdef CMD_TIMEOUT_EN
      to_cnt_q     <= '0;
`endif
    end else begin
      read_uart_q  <= 1'b0;
      write_uart_q <= 1'b0;
      cmd_stb_q    <= 1'b0;
`ifdef CMD_TIMEOUT_EN
      if (to_run) to_cnt_q <= to_cnt_q + TW'(1);
      else        to_cnt_q <= '0;
`endif
      if (state_q == SEND) begin
        if (!bus.tx_full) begin
          write_uart_q <= 1'b1;
          write_data_q <= rbuf_q[idx_q];
          idx_q        <= idx_q + 2'd1;
          if (idx_q == last_q) state_q <= IDLE;
        end
      end else if (read_uart_q) begin
        // read_data is still the popped byte during the pop cycle (FWFT head).
        case (state_q)
          IDLE: begin
            if (rx_up == CH_W)      state_q <= W_HI;
            else if (rx_up == CH_R) state_q <= R_END;
            else if (bus.read_data != CH_CR && bus.read_data != CH_LF) state_q <= FLUSH;
          end
          W_HI, W_LO: begin
            if (hex_vld) begin
              if (state_q == W_HI) begin
                wdat_q[7:4] <= hex_nib;
                state_q     <= W_LO;
              end else begin
                wdat_q[3:0] <= hex_nib;
                state_q     <= W_END;
              end
            end else if (bus.read_data == CH_CR) begin
              rbuf_q    <= ERR_RPL;
              last_q    <= 2'd2;
              idx_q     <= 2'd0;
              err_cnt_q <= err_cnt_d;
              state_q   <= SEND;
            end else begin
              state_q <= FLUSH;
            end
          end
          W_END: begin
            if (bus.read_data == CH_CR) begin
              led_q     <= wdat_q;
              cmd_stb_q <= 1'b1;
              rbuf_q    <= OK_RPL;
              last_q    <= 2'd2;
              idx_q     <= 2'd0;
              state_q   <= SEND;
            end else begin
              state_q <= FLUSH;
            end
          end
          R_END: begin
            if (bus.read_data == CH_CR) begin
              rbuf_q  <= {CH_LF, CH_CR, hex_char(led_q[3:0]), hex_char(led_q[7:4])};
              last_q  <= 2'd3;
              idx_q   <= 2'd0;
              state_q <= SEND;
            end else begin
              state_q <= FLUSH;
            end
          end
          FLUSH: begin
            if (bus.read_data == CH_CR) begin
              rbuf_q    <= ERR_RPL;
              last_q    <= 2'd2;
              idx_q     <= 2'd0;
              err_cnt_q <= err_cnt_d;
              state_q   <= SEND;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
`ifdef CMD_TIMEOUT_EN
      else if (to_hit) begin
        state_q   <= IDLE;
        err_cnt_q <= err_cnt_d;
        to_cnt_q  <= '0;
      end
`endif
      else if (!bus.rx_empty) begin
        read_uart_q <= 1'b1;
      end
    end
  end

  assign bus.read_uart  = read_uart_q;
  assign bus.write_uart = write_uart_q;
  assign bus.write_data = write_data_q;
  assign led            = led_q;
  assign cmd_stb        = cmd_stb_q;
  assign err_cnt        = err_cnt_q;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Bench for uart_cmd_parser: queue-backed RX/TX FIFO models, line-level reference model and
// a scoreboard monitor that checks every TX push, every cmd_stb and the pop discipline.
module tb_uart_cmd_parser;
  localparam logic [7:0] LED_RST = 8'hC3;
  localparam byte unsigned CR = 8'h0D;
  localparam byte unsigned LF = 8'h0A;

  typedef byte unsigned bq_t[$];

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] led;
  logic [7:0] err_cnt;
  logic       cmd_stb;

  uart_cmd_parser_if u_if ();

  uart_cmd_parser #(
    .LED_RESET(LED_RST)
`ifdef CMD_TIMEOUT_EN
    , .TIMEOUT_CYCLES(50)
`endif
  ) dut (
    .CLK    (clk),
    .RST_N  (rst_n),
    .bus    (u_if.master),
    .led    (led),
    .cmd_stb(cmd_stb),
    .err_cnt(err_cnt)
  );

  int         total = 0;
  int         bad = 0;
  bq_t        rx_q;
  bq_t        exp_tx;
  bq_t        m_cur;
  logic [7:0] exp_led_q[$];
  logic [7:0] m_led = LED_RST;
  int         m_err = 0;
  bit         pop_seen = 0, tx_hold = 0, rand_full = 0, prev_rd = 0, prev_full = 0, lat_armed = 0;
  int         wcount = 0, cyc = 0, last_pop_cyc = 0;
  string      hexdig = "0123456789ABCDEF";
  string      anyhex = "0123456789abcdefABCDEF";
  string      junk = "WRwr0aFgX5\n ";

  initial forever #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int hexval(input byte unsigned c);
    if (c >= 8'h30 && c <= 8'h39) return int'(c) - 48;
    if (c >= 8'h41 && c <= 8'h46) return int'(c) - 55;
    if (c >= 8'h61 && c <= 8'h66) return int'(c) - 87;
    return -1;
  endfunction

  function automatic byte unsigned upc(input byte unsigned c);
    return (c >= 8'h61 && c <= 8'h7A) ? c - 8'h20 : c;
  endfunction

  // Reference model: one call per CR-terminated line; leading LFs are blank-line noise.
  task automatic model_line(input bq_t ln);
    bq_t b;
    b = ln;
    while (b.size() > 0 && b[0] == LF) void'(b.pop_front());
    if (b.size() == 0) return;
    foreach (b[i]) b[i] = upc(b[i]);
    if (b.size() == 3 && b[0] == 8'h57 && hexval(b[1]) >= 0 && hexval(b[2]) >= 0) begin
      m_led = 8'(hexval(b[1]) * 16 + hexval(b[2]));
      exp_led_q.push_back(m_led);
      exp_tx.push_back(8'h4B);
      exp_tx.push_back(CR);
      exp_tx.push_back(LF);
    end else if (b.size() == 1 && b[0] == 8'h52) begin
      exp_tx.push_back(hexdig[int'(m_led[7:4])]);
      exp_tx.push_back(hexdig[int'(m_led[3:0])]);
      exp_tx.push_back(CR);
      exp_tx.push_back(LF);
    end else begin
      m_err = (m_err < 255) ? m_err + 1 : 255;
      exp_tx.push_back(8'h3F);
      exp_tx.push_back(CR);
      exp_tx.push_back(LF);
    end
  endtask

  task automatic send(input bq_t s);
    foreach (s[i]) begin
      rx_q.push_back(s[i]);
      if (s[i] == CR) begin
        model_line(m_cur);
        m_cur.delete();
      end else begin
        m_cur.push_back(s[i]);
      end
    end
  endtask

  function automatic bq_t s2q(input string s);
    bq_t q;
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
    return q;
  endfunction

  function automatic bq_t gen_cmd();
    bq_t q;
    int  k = $urandom_range(0, 4);
    int  n = $urandom_range(1, 4);
    if (k == 4) begin
      q.push_back(LF);
      q.push_back(CR);
    end
    if (k <= 1 || k == 4) begin
      q.push_back($urandom_range(0, 1) ? 8'h57 : 8'h77);
      q.push_back(anyhex[$urandom_range(0, 21)]);
      q.push_back(anyhex[$urandom_range(0, 21)]);
    end else if (k == 2) begin
      q.push_back($urandom_range(0, 1) ? 8'h52 : 8'h72);
    end else begin
      for (int i = 0; i < n; i++) q.push_back(junk[$urandom_range(0, 11)]);
    end
    q.push_back(CR);
    return q;
  endfunction

  task automatic drain(input string nm);
    int n = 0;
    while ((rx_q.size() != 0 || exp_tx.size() != 0) && n < 10000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 10000) begin
      total++;
      bad++;
      $display("FAIL %s_drain: %0d reply bytes outstanding after %0d cycles", nm, exp_tx.size(), n);
    end
    repeat (8) @(negedge clk);
    chk({nm, "_led"}, led, m_led);
    chk({nm, "_err"}, err_cnt, m_err);
    chk({nm, "_stb_missing"}, exp_led_q.size(), 0);
  endtask

  // RX/TX FIFO side: inputs change 1 time unit after the active edge.
  initial begin
    u_if.rx_empty  = 1'b1;
    u_if.read_data = 8'h00;
    u_if.tx_full   = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (pop_seen) begin
        if (rx_q.size() > 0) void'(rx_q.pop_front());
        pop_seen = 0;
      end
      u_if.rx_empty  = (rx_q.size() == 0);
      u_if.read_data = (rx_q.size() == 0) ? 8'h00 : rx_q[0];
      u_if.tx_full   = tx_hold || (rand_full && ($urandom_range(0, 3) == 0));
    end
  end

  // Monitor / scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (rst_n) begin
        if (u_if.read_uart) begin
          pop_seen = 1;
          last_pop_cyc = cyc;
          chk("pop_spacing", prev_rd, 0);
          chk("pop_nonempty", rx_q.size() > 0, 1);
        end
        if (u_if.write_uart) begin
          wcount++;
          chk("push_while_full", prev_full, 0);
          if (lat_armed) begin
            chk("reply_latency", cyc - last_pop_cyc, 2);
            lat_armed = 0;
          end
          if (exp_tx.size() == 0) begin
            total++;
            bad++;
            $display("FAIL tx_extra: got byte %0h with no reply outstanding", u_if.write_data);
          end else begin
            chk("tx_byte", u_if.write_data, exp_tx.pop_front());
          end
        end
        if (cmd_stb) begin
          chk("stb_timing", cyc - last_pop_cyc, 1);
          if (exp_led_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL stb_extra: cmd_stb with led=%0h and no write pending", led);
          end else begin
            chk("led_at_stb", led, exp_led_q.pop_front());
          end
        end
      end
      prev_rd   = u_if.read_uart;
      prev_full = u_if.tx_full;
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int w0;
    int n;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_led", led, LED_RST);
    chk("rst_err", err_cnt, 0);
    chk("rst_rd", u_if.read_uart, 0);
    chk("rst_wr", u_if.write_uart, 0);
    chk("rst_wdata", u_if.write_data, 0);
    chk("rst_stb", cmd_stb, 0);
    rst_n = 1'b1;

    send(s2q("W5A\r"));
    drain("w5a");
    lat_armed = 1;
    send(s2q("r\r"));
    drain("read");
    chk("latency_seen", lat_armed, 0);
    send(s2q("Wg1\r"));
    send(s2q("X\r"));
    drain("errs");

    // Hold TX full for 20 cycles in the middle of a read reply.
    send(s2q("R\r"));
    w0 = wcount;
    n = 0;
    while (wcount == w0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("hold_first_push", n < 200, 1);
    tx_hold = 1;
    repeat (2) @(negedge clk);
    w0 = wcount;
    repeat (18) @(negedge clk);
    chk("hold_no_push", wcount, w0);
    chk("hold_pending", exp_tx.size() > 0, 1);
    tx_hold = 0;
    drain("hold");

    // Reset in the middle of a partial write command.
    send(s2q("W3"));
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    m_led = LED_RST;
    m_err = 0;
    m_cur.delete();
    chk("rst2_led", led, LED_RST);
    chk("rst2_err", err_cnt, 0);
    send(s2q("R\r"));
    drain("after_rst");

`ifdef CMD_TIMEOUT_EN
    w0 = wcount;
    send(s2q("W1"));
    repeat (80) @(negedge clk);
    m_err = m_err + 1;
    m_cur.delete();
    chk("to_err", err_cnt, m_err);
    chk("to_no_tx", wcount, w0);
    send(s2q("W22\r"));
    drain("to_recover");
    chk("to_led", led, 8'h22);
`endif

    rand_full = 1;
    for (int b = 0; b < 5; b++) begin
      for (int i = 0; i < 10; i++) send(gen_cmd());
      drain("rand");
    end
    rand_full = 0;

    for (int i = 0; i < 260; i++) send(s2q("X\r"));
    drain("sat");
    chk("sat_err", err_cnt, 8'hFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
